// File: rtl/dac_pkg.sv
// Shared definitions for the sigma-delta DAC front end: interpolator states,
// legal ramp-length range and the underrun counter width.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } interp_state_e;

    localparam int RATIO_LOG2_MIN = 1;
    localparam int RATIO_LOG2_MAX = 12;
    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/dac_sample_fifo.sv
// Two-entry sample FIFO with synchronous clear; push and pop may coincide
// whenever the FIFO is not empty (the owner never pushes when full).
module dac_sample_fifo
    import dac_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Next pointers, storage and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);

endmodule

// File: rtl/dac_sample_interpolator.sv
// Linear interpolator feeding the sigma-delta DAC: ramps between buffered PCM
// samples over 2^RATIO_LOG2 clocks. Define DAC_INTERP_UNDERRUN_COUNT_EN to add
// a saturating underrun_count output.
module dac_sample_interpolator
    import dac_pkg::*;
#(
    parameter int SIGNALWIDTH = 16,
    parameter int RATIO_LOG2  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [SIGNALWIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [SIGNALWIDTH-1:0] q,
    output logic                   underrun,
    output logic                   busy
`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

    localparam int W  = SIGNALWIDTH;
    localparam int R  = RATIO_LOG2;
    localparam int AW = W + R + 1;

    if (RATIO_LOG2 < RATIO_LOG2_MIN || RATIO_LOG2 > RATIO_LOG2_MAX) begin : g_bad_ratio
        $error("dac_sample_interpolator: RATIO_LOG2 outside supported range");
    end

    function automatic logic [W:0] ext_diff(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    function automatic logic [AW-1:0] to_acc(input logic [W-1:0] x);
        return {x[W-1], x, {R{1'b0}}};
    endfunction

    interp_state_e  state_q, state_d;
    logic [W-1:0]   cur_q, cur_d;
    logic [W:0]     diff_q, diff_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [R-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   q_q, q_d;
    logic           underrun_q, underrun_d;
    logic           busy_q, busy_d;

    logic           push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [W-1:0]   head_s;
    logic [AW-1:0]  acc_step_s;
    logic [W-1:0]   ramp_val_s;

    assign in_ready = enable && !fifo_full_s && !reset;
    assign push_s   = in_valid && in_ready;

    dac_sample_fifo #(
        .WIDTH (W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (!enable),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (in_data),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // The accumulator carries R fractional bits; floor of acc is its upper W bits.
    assign acc_step_s = acc_q + {{R{diff_q[W]}}, diff_q};
    assign ramp_val_s = acc_step_s[R +: W];

    // Interpolator sequencing and datapath next state.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        diff_d     = diff_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        underrun_d = 1'b0;
        pop_s      = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cur_d   = '0;
            diff_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
            q_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cur_d = '0;
                    q_d   = '0;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        diff_d  = ext_diff(head_s) - ext_diff({W{1'b0}});
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_RAMP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RAMP: begin
                    acc_d = acc_step_s;
                    cnt_d = cnt_q + {{(R-1){1'b0}}, 1'b1};
                    q_d   = ramp_val_s;
                    // Final step lands exactly on the target; chain the next ramp with no gap.
                    if (cnt_q == {R{1'b1}}) begin
                        cur_d = ramp_val_s;
                        if (!fifo_empty_s) begin
                            pop_s  = 1'b1;
                            diff_d = ext_diff(head_s) - ext_diff(ramp_val_s);
                        end else begin
                            state_d    = ST_HOLD;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
                ST_HOLD: begin
                    q_d = cur_q;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        diff_d  = ext_diff(head_s) - ext_diff(cur_q);
                        acc_d   = to_acc(cur_q);
                        cnt_d   = '0;
                        state_d = ST_RAMP;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                    q_d     = '0;
                end
            endcase
        end
        busy_d = (state_d == ST_RAMP);
    end

    // Interpolator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            diff_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            diff_q     <= diff_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

    assign q        = q_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;

`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

    // Saturating underrun tally; held clear while disabled.
    always_comb begin
        ucnt_d = ucnt_q;
        if (!enable) begin
            ucnt_d = '0;
        end else if (underrun_d && (ucnt_q != {UNDERRUN_CNT_W{1'b1}})) begin
            ucnt_d = ucnt_q + {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_dac_sample_interpolator.sv
// Self-checking bench for dac_sample_interpolator (RATIO_LOG2 = 2): directed
// scenarios plus random traffic against a closed-form interpolation model.
module tb_dac_sample_interpolator;

    localparam int W = 16;
    localparam int R = 2;
    localparam int N = 1 << R;

    logic         clk = 1'b0;
    logic         reset, enable, in_valid, in_ready, underrun, busy;
    logic [W-1:0] in_data, q;
`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
    logic [15:0]  underrun_count;
`endif

    dac_sample_interpolator #(
        .SIGNALWIDTH (W),
        .RATIO_LOG2  (R)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q        (q),
        .underrun (underrun),
        .busy     (busy)
`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: mode 0 idle, 1 ramp, 2 hold.
    int m_fifo[$];
    int m_mode, m_cur, m_start, m_tgt, m_k, m_q, m_und, m_ucnt;
    bit last_accept;
    int qlog[$];
    int ulog[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int interp(input int a, input int b, input int k);
        longint p;
        p = longint'(k) * (longint'(b) - longint'(a));
        return a + int'(p >>> R);
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_mode  = 0;
        m_cur   = 0;
        m_q     = 0;
        m_und   = 0;
        m_k     = 0;
        m_start = 0;
        m_tgt   = 0;
    endtask

    task automatic model_load(input int from);
        m_start = from;
        m_tgt   = m_fifo.pop_front();
        m_k     = 0;
        m_mode  = 1;
    endtask

    task automatic compare_outputs();
        check("q", 32'($signed(q)), m_q);
        check("underrun", {31'd0, underrun}, m_und);
        check("busy", {31'd0, busy}, (m_mode == 1) ? 1 : 0);
        check("in_ready", {31'd0, in_ready}, (enable && !reset && m_fifo.size() < 2) ? 1 : 0);
`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
        check("underrun_count", {16'd0, underrun_count}, m_ucnt);
`endif
    endtask

    task automatic tick();
        bit accept, avail;
        @(posedge clk);
        accept = enable && !reset && in_valid && (m_fifo.size() < 2);
        m_und  = 0;
        if (reset) begin
            model_clear();
            m_ucnt = 0;
        end else if (!enable) begin
            model_clear();
            m_ucnt = 0;
        end else begin
            avail = (m_fifo.size() > 0);
            case (m_mode)
                0: begin
                    m_q = 0;
                    if (avail) model_load(0);
                end
                1: begin
                    m_k++;
                    m_q = interp(m_start, m_tgt, m_k);
                    if (m_k == N) begin
                        m_cur = m_tgt;
                        if (avail) model_load(m_tgt);
                        else begin
                            m_mode = 2;
                            m_und  = 1;
                            if (m_ucnt < 65535) m_ucnt++;
                        end
                    end
                end
                default: begin
                    m_q = m_cur;
                    if (avail) model_load(m_cur);
                end
            endcase
            if (accept) m_fifo.push_back(int'($signed(in_data)));
        end
        last_accept = accept;
        cycle++;
        #1;
        qlog.push_back(int'($signed(q)));
        ulog.push_back(int'(underrun));
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int v);
        int n;
        in_valid = 1'b1;
        in_data  = v[15:0];
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 64);
        in_valid = 1'b0;
        check("push_accept", {31'd0, last_accept}, 1);
    endtask

    task automatic expect_seq(input string tag, input int from, input int a, input int b,
                              input int c, input int d);
        int found;
        found = 0;
        for (int i = from; i + 3 < qlog.size(); i++) begin
            if (qlog[i] == a && qlog[i+1] == b && qlog[i+2] == c && qlog[i+3] == d) found = 1;
        end
        check(tag, found, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_clear();
        m_ucnt = 0;
        #1;
        check("rst_q", 32'($signed(q)), 0);
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_underrun", {31'd0, underrun}, 0);
`ifdef DAC_INTERP_UNDERRUN_COUNT_EN
        check("rst_ucount", {16'd0, underrun_count}, 0);
`endif
        run(2);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int mark, pulses, held, accepted, bad;
        int acc_cyc[$];
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_clear();
        m_ucnt = 0;
        #1;
        check("init_q", 32'($signed(q)), 0);
        check("init_ready", {31'd0, in_ready}, 0);
        run(2);
        #2;
        reset  = 1'b0;
        enable = 1'b1;

        // Rising ramp: 0 then 400.
        mark = qlog.size();
        push(0);
        push(400);
        run(10);
        expect_seq("rising", mark, 100, 200, 300, 400);

        // Falling ramp, back-to-back samples.
        mark = qlog.size();
        push(400);
        push(-400);
        run(12);
        expect_seq("falling", mark, 200, 0, -200, -400);

        // Underrun and hold.
        mark = qlog.size();
        push(1000);
        run(56);
        pulses = 0;
        held   = 0;
        for (int i = mark; i < qlog.size(); i++) begin
            pulses += ulog[i];
            if (qlog[i] == 1000) held++;
        end
        check("underrun_pulses", pulses, 1);
        check("hold_1000", (held >= 50) ? 1 : 0, 1);
        mark = qlog.size();
        push(0);
        run(8);
        expect_seq("ramp_down", mark, 750, 500, 250, 0);

        // Full-scale swap.
        mark = qlog.size();
        push(32767);
        push(-32768);
        run(12);
        expect_seq("full_scale", mark, 16383, -1, -16385, -32768);
        check("full_scale_end", 32'($signed(q)), -32768);

        // Backpressure: in_valid held high for 20 samples.
        accepted = 0;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        for (int i = 0; i < 200 && accepted < 20; i++) begin
            tick();
            if (last_accept) begin
                accepted++;
                acc_cyc.push_back(cycle);
                in_data = 16'($urandom);
            end
        end
        in_valid = 1'b0;
        check("bp_count", accepted, 20);
        bad = 0;
        for (int i = 3; i < acc_cyc.size(); i++) begin
            if (acc_cyc[i] - acc_cyc[i-1] != N) bad++;
        end
        check("bp_interval", bad, 0);
        run(100);

        // Random traffic with occasional enable drops.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 99) < 35);
            in_data  = 16'($urandom);
            enable   = ($urandom_range(0, 99) >= 3);
            tick();
        end
        enable   = 1'b1;
        in_valid = 1'b0;
        run(20);

        // Enable drop mid-ramp.
        push(500);
        push(600);
        run(2);
        enable = 1'b0;
        tick();
        check("en_low_q", 32'($signed(q)), 0);
        check("en_low_ready", {31'd0, in_ready}, 0);
        enable = 1'b1;
        mark = qlog.size();
        push(800);
        run(8);
        expect_seq("after_enable", mark, 200, 400, 600, 800);

        // Asynchronous reset mid-ramp.
        push(1000);
        push(2000);
        run(3);
        do_reset();
        mark = qlog.size();
        push(1200);
        run(8);
        expect_seq("after_reset", mark, 300, 600, 900, 1200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
